// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants for the boot loader slice.
//   AW        - memory address / data width
//   S_*       - 3-bit loader FSM state encodings (IDLE must stay zero)
//   BYTE_HI/LO- stream byte order: high byte of each 16-bit field first
package prog_loader_pkg;
    localparam int unsigned AW = 16;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DAT_HI = 3'd3;
    localparam logic [2:0] S_DAT_LO = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_RUN    = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;
    localparam int unsigned BYTE_HI = 0;
    localparam int unsigned BYTE_LO = 1;
endpackage

// File: rtl/prog_loader_mem_port_mux.sv
// mem_port_mux: selects who drives the single memory port.
//   owner_cpu - 1: processor drives mem_*, 0: loader drives mem_*
//   ld_*      - loader write enable / address / data
//   cpu_*     - processor write enable / address / data
//   mem_*     - memory port write enable / address / data
module mem_port_mux
    import prog_loader_pkg::*;
(
    input  logic          owner_cpu,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [AW-1:0] ld_din,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [AW-1:0] cpu_din,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_din
);
    assign mem_we   = owner_cpu ? cpu_we   : ld_we;
    assign mem_addr = owner_cpu ? cpu_addr : ld_addr;
    assign mem_din  = owner_cpu ? cpu_din  : ld_din;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader and memory-port owner.
//   clk, reset (sync, active-low), start (reload pulse)
//   byte_in/byte_valid/byte_ready - length-prefixed big-endian byte stream
//   cpu_mw_en/cpu_Address/cpu_D_out - processor memory port, passed through in RUN
//   mem_we/mem_addr/mem_din - memory port
//   cpu_reset, busy, done, err, words_loaded - status
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [15:0] LOAD_BASE = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        cpu_mw_en,
    input  logic [15:0] cpu_Address,
    input  logic [15:0] cpu_D_out,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);
    logic [2:0]  state_q, state_d;
    logic [15:0] count_q, count_d, idx_q, idx_d, word_q, word_d, words_q, words_d;
    logic        xfer;

    assign byte_ready   = state_q inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO};
    assign busy         = byte_ready | (state_q == S_WRITE);
    assign done         = state_q == S_RUN;
    assign err          = state_q == S_ERROR;
    assign cpu_reset    = !done;
    assign words_loaded = words_q;
    assign xfer         = byte_valid & byte_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        word_d  = word_q;
        words_d = words_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: if (start) begin
                state_d = S_LEN_HI;
                words_d = '0;
            end
            S_LEN_HI: if (xfer) begin
                count_d[15:8] = byte_in;
                state_d       = S_LEN_LO;
            end
            S_LEN_LO: if (xfer) begin
                count_d[7:0] = byte_in;
                idx_d        = '0;
                state_d      = (count_d == 16'd0) ? S_RUN :
                               (32'(count_d) > MAX_WORDS) ? S_ERROR : S_DAT_HI;
            end
            S_DAT_HI: if (xfer) begin
                word_d[15:8] = byte_in;
                state_d      = S_DAT_LO;
            end
            S_DAT_LO: if (xfer) begin
                word_d[7:0] = byte_in;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                idx_d   = idx_q + 16'd1;
                words_d = words_q + 16'd1;
                state_d = (idx_d == count_q) ? S_RUN : S_DAT_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            words_q <= words_d;
        end
    end

    // Address arithmetic wraps modulo 2^16 by width truncation.
    mem_port_mux u_mux (
        .owner_cpu (done),
        .ld_we     (state_q == S_WRITE),
        .ld_addr   (LOAD_BASE + idx_q),
        .ld_din    (word_q),
        .cpu_we    (cpu_mw_en),
        .cpu_addr  (cpu_Address),
        .cpu_din   (cpu_D_out),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din)
    );
endmodule
